// File: rtl/vga_pixel_feeder.sv
// -----------------------------------------------------------------------------
// vga_pixel_feeder
//
// Upstream stage of the VGA scan-out block. Owns the ping-pong pixel storage
// register that scan-out reads. It fills every slot once after reset or zoom
// (prime), raises start, and then refills the upper half (slots SLOTS-1..HALF)
// or the lower half (slots HALF-1..0) whenever scan-out asks for one.
// Slots are always written in descending order, one pixel per accepted
// handshake.
//
// Optional build macro:
//   VGA_FEEDER_TESTPAT_EN - pixels come from an internal always-valid pattern
//                           generator instead of in_valid/in_data.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   zoom        view change: flush the buffer and re-prime (highest priority)
//   need_pixel  scan-out request pulse: 1 = refill upper, 2 = refill lower
//   in_valid    input pixel valid
//   in_data     input pixel, RGB565
//   in_ready    feeder accepts in_data this cycle (state decode, no path
//               from in_valid)
//   storage     pixel slots, slot k at bits [k*PIX_W +: PIX_W]
//   store_coun  pixels held and not yet consumed (0..SLOTS)
//   start       buffer primed, scan-out may run
//   underrun    sticky: scan-out re-requested a half that was never refilled
// -----------------------------------------------------------------------------
module vga_pixel_feeder #(
   parameter int SLOTS = 80,
   parameter int PIX_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     zoom,
   input  logic [1:0]               need_pixel,
   input  logic                     in_valid,
   input  logic [PIX_W-1:0]         in_data,
   output logic                     in_ready,
   output logic [SLOTS*PIX_W-1:0]   storage,
   output logic [10:0]              store_coun,
   output logic                     start,
   output logic                     underrun
);

   localparam int HALF   = SLOTS / 2;
   localparam int SLOT_W = $clog2(SLOTS);

   localparam logic [SLOT_W-1:0] SLOT_TOP   = SLOT_W'(SLOTS - 1);
   localparam logic [SLOT_W-1:0] SLOT_MID   = SLOT_W'(HALF - 1);
   localparam logic [SLOT_W-1:0] SLOT_HI_LO = SLOT_W'(HALF);
   localparam logic [SLOT_W-1:0] SLOT_ZERO  = '0;
   localparam logic [10:0]       CNT_HALF   = 11'(HALF);
   localparam logic [10:0]       CNT_FULL   = 11'(SLOTS);

   typedef enum logic [1:0] {
      ST_PRIME,
      ST_WAIT,
      ST_FILL_HI,
      ST_FILL_LO
   } state_t;

   state_t            state;
   logic [SLOT_W-1:0] slot;
   logic              pend_hi;
   logic              pend_lo;

   logic [PIX_W-1:0]  pix;
   logic              accept;
   logic              req_hi;
   logic              req_lo;
   logic              last_write;
   logic [10:0]       cnt_after_req;

   // Ready is a pure decode of the registered state; zoom and rst only mask it
   // so no write can slip in during a flush.
   assign in_ready = (state != ST_WAIT) && !zoom && !rst;

`ifdef VGA_FEEDER_TESTPAT_EN
   logic [5:0] pat_x;

   assign pix    = PIX_W'({pat_x[4:0], pat_x, pat_x[4:0]});
   assign accept = in_ready;
`else
   assign pix    = in_data;
   assign accept = in_valid && in_ready;
`endif

   // Requests are ignored while priming; 3 is not a valid request.
   assign req_hi = (need_pixel == 2'd1) && (state != ST_PRIME);
   assign req_lo = (need_pixel == 2'd2) && (state != ST_PRIME);

   // NOTE: every signal driven in always_comb gets a value on every path
   // (defaults first) so no latch is inferred.
   always_comb begin
      last_write    = 1'b0;
      cnt_after_req = store_coun;
      unique case (state)
         ST_FILL_HI: last_write = accept && (slot == SLOT_HI_LO);
         ST_PRIME,
         ST_FILL_LO: last_write = accept && (slot == SLOT_ZERO);
         default:    last_write = 1'b0;
      endcase
      if (req_hi || req_lo)
         cnt_after_req = (store_coun >= CNT_HALF) ? store_coun - CNT_HALF : 11'd0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: storage is a register bank feeding scan-out directly, not a
         // RAM, so it is cleared on reset to give a defined first frame.
         storage    <= '0;
         store_coun <= '0;
         start      <= 1'b0;
         underrun   <= 1'b0;
         state      <= ST_PRIME;
         slot       <= SLOT_TOP;
         pend_hi    <= 1'b0;
         pend_lo    <= 1'b0;
`ifdef VGA_FEEDER_TESTPAT_EN
         pat_x      <= '0;
`endif
      end else if (zoom) begin
         // Flush: storage contents are kept, everything else restarts.
         store_coun <= '0;
         start      <= 1'b0;
         state      <= ST_PRIME;
         slot       <= SLOT_TOP;
         pend_hi    <= 1'b0;
         pend_lo    <= 1'b0;
`ifdef VGA_FEEDER_TESTPAT_EN
         pat_x      <= '0;
`endif
      end else begin
         if (accept)
            storage[int'(slot)*PIX_W +: PIX_W] <= pix;

`ifdef VGA_FEEDER_TESTPAT_EN
         if (accept)
            pat_x <= pat_x + 6'd1;
`endif

         // A request that lands on the final write of its own half wins over
         // the clear, so it is never lost.
         pend_hi <= (pend_hi && !(last_write && state == ST_FILL_HI)) || req_hi;
         pend_lo <= (pend_lo && !(last_write && state == ST_FILL_LO)) || req_lo;

         if ((req_hi && pend_hi) || (req_lo && pend_lo))
            underrun <= 1'b1;

         // Count moves only per request and per completed fill, never per pixel.
         if (last_write && state == ST_PRIME)
            store_coun <= CNT_FULL;
         else if (last_write)
            store_coun <= cnt_after_req + CNT_HALF;
         else
            store_coun <= cnt_after_req;

         unique case (state)
            ST_PRIME: begin
               if (accept) begin
                  if (slot == SLOT_ZERO) begin
                     start <= 1'b1;
                     state <= ST_WAIT;
                  end else begin
                     slot <= slot - SLOT_W'(1);
                  end
               end
            end
            ST_WAIT: begin
               // Upper half is served first when both are pending.
               if (pend_hi) begin
                  state <= ST_FILL_HI;
                  slot  <= SLOT_TOP;
               end else if (pend_lo) begin
                  state <= ST_FILL_LO;
                  slot  <= SLOT_MID;
               end
            end
            ST_FILL_HI: begin
               if (accept) begin
                  if (slot == SLOT_HI_LO)
                     state <= ST_WAIT;
                  else
                     slot <= slot - SLOT_W'(1);
               end
            end
            ST_FILL_LO: begin
               if (accept) begin
                  if (slot == SLOT_ZERO)
                     state <= ST_WAIT;
                  else
                     slot <= slot - SLOT_W'(1);
               end
            end
            default: state <= ST_PRIME;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_feeder
//
// Scenario-level bench for vga_pixel_feeder. The reference model is the
// expected content of every slot: each scenario knows which slot range it
// fills (descending) and records the pixel it pushes into exp_mem, plus the
// counter, start and underrun values that follow from the request history.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_pixel_feeder;

   localparam int SLOTS = 80;
   localparam int PIX_W = 16;
   localparam int HALF  = SLOTS / 2;

`ifdef VGA_FEEDER_TESTPAT_EN
   localparam bit TESTPAT = 1'b1;
`else
   localparam bit TESTPAT = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     zoom;
   logic [1:0]               need_pixel;
   logic                     in_valid;
   logic [PIX_W-1:0]         in_data;
   logic                     in_ready;
   logic [SLOTS*PIX_W-1:0]   storage;
   logic [10:0]              store_coun;
   logic                     start;
   logic                     underrun;

   vga_pixel_feeder #(.SLOTS(SLOTS), .PIX_W(PIX_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .zoom       (zoom),
      .need_pixel (need_pixel),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .storage    (storage),
      .store_coun (store_coun),
      .start      (start),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   int               tests_run    = 0;
   int               tests_failed = 0;
   logic [PIX_W-1:0] exp_mem [SLOTS];
   logic [PIX_W-1:0] pix_q [$];
   int               wr_x;

   function automatic logic [PIX_W-1:0] pat(input int x);
      logic [5:0] b;
      b = x[5:0];
      return {b[4:0], b, b[4:0]};
   endfunction

   function automatic logic [PIX_W-1:0] slot_val(input int k);
      return storage[k*PIX_W +: PIX_W];
   endfunction

   // First slot whose content differs from the model, -1 when all agree.
   function automatic int first_bad_slot();
      for (int k = SLOTS - 1; k >= 0; k--)
         if (slot_val(k) !== exp_mem[k]) return k;
      return -1;
   endfunction

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) pix_q.push_back(PIX_W'($urandom));
   endtask

   // Streams n pixels from pix_q into slots start_slot, start_slot-1, ...
   // valid_pct randomises in_valid; gap_after forces 5 idle cycles once that
   // many pixels have been accepted; two optional request pulses are issued at
   // the given cycle offsets. Returns cycles in which in_ready was low.
   task automatic stream(input int n, input int start_slot, input int valid_pct,
                         input int gap_after, input int ra_cyc, input logic [1:0] ra_val,
                         input int rb_cyc, input logic [1:0] rb_val, input string name,
                         output int stalls);
      int i = 0;
      int cyc = 0;
      int gap_left = 5;
      logic v;
      logic [PIX_W-1:0] d;
      stalls = 0;
      while (i < n && cyc < 1000) begin
         need_pixel = (cyc == ra_cyc) ? ra_val : (cyc == rb_cyc) ? rb_val : 2'd0;
         if (in_ready !== 1'b1) begin
            stalls++;
            in_valid = 1'b0;
         end else begin
            v = ($urandom_range(99) < valid_pct);
            if (gap_after >= 0 && i == gap_after && gap_left > 0) begin
               v = 1'b0;
               gap_left--;
            end
            d        = pix_q[0];
            in_data  = d;
            in_valid = v;
            if (v || TESTPAT) begin
               void'(pix_q.pop_front());
               exp_mem[start_slot - i] = TESTPAT ? pat(wr_x) : d;
               wr_x++;
               i++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      need_pixel = 2'd0;
      in_valid   = 1'b0;
      tests_run++;
      if (i != n) begin
         tests_failed++;
         $display("FAIL %s stream: accepted %0d pixels, wanted %0d", name, i, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      wr_x = 0;
      for (int k = 0; k < SLOTS; k++) exp_mem[k] = '0;
      tests_run++;
      if (storage !== '0) begin tests_failed++; $display("FAIL reset storage: got nonzero, want 0"); end
      tests_run++;
      if (store_coun !== 11'd0) begin tests_failed++; $display("FAIL reset store_coun: got %0d want 0", store_coun); end
      tests_run++;
      if (start !== 1'b0) begin tests_failed++; $display("FAIL reset start: got %b want 0", start); end
      tests_run++;
      if (underrun !== 1'b0) begin tests_failed++; $display("FAIL reset underrun: got %b want 0", underrun); end
   endtask

   task automatic test_prime();
      int st;
      int bad;
      for (int i = 0; i < SLOTS; i++) pix_q.push_back(PIX_W'(i));
      stream(SLOTS - 1, SLOTS - 1, 100, -1, -1, 2'd0, -1, 2'd0, "prime", st);
      tests_run++;
      if (start !== 1'b0 || st != 0) begin tests_failed++; $display("FAIL prime early: start=%b stalls=%0d want 0/0", start, st); end
      stream(1, 0, 100, -1, -1, 2'd0, -1, 2'd0, "prime_last", st);
      tests_run++;
      if (start !== 1'b1) begin tests_failed++; $display("FAIL prime start: got %b want 1", start); end
      tests_run++;
      if (store_coun !== 11'd80) begin tests_failed++; $display("FAIL prime store_coun: got %0d want 80", store_coun); end
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL prime in_ready idle: got %b want 0", in_ready); end
      bad = first_bad_slot();
      tests_run++;
      if (bad != -1) begin tests_failed++; $display("FAIL prime storage: slot %0d got %h want %h", bad, slot_val(bad), exp_mem[bad]); end
      if (!TESTPAT) begin
         tests_run++;
         if (slot_val(79) !== 16'h0000 || slot_val(0) !== 16'h004F) begin
            tests_failed++;
            $display("FAIL prime ends: slot79=%h slot0=%h want 0000/004f", slot_val(79), slot_val(0));
         end
      end
   endtask

   task automatic test_upper_refill();
      int st;
      int bad;
      need_pixel = 2'd1;
      @(negedge clk);
      need_pixel = 2'd0;
      tests_run++;
      if (store_coun !== 11'd40 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL upper capture: store_coun=%0d in_ready=%b want 40/0", store_coun, in_ready);
      end
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL upper latency: in_ready=%b want 1 two cycles after request", in_ready); end
      for (int i = 0; i < HALF; i++) pix_q.push_back(16'hA000 + PIX_W'(i));
      stream(HALF, SLOTS - 1, 100, -1, -1, 2'd0, -1, 2'd0, "upper", st);
      tests_run++;
      if (st != 0 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL upper ready window: stalls=%0d in_ready_after=%b want 0/0", st, in_ready); end
      tests_run++;
      if (store_coun !== 11'd80) begin tests_failed++; $display("FAIL upper store_coun: got %0d want 80", store_coun); end
      bad = first_bad_slot();
      tests_run++;
      if (bad != -1) begin tests_failed++; $display("FAIL upper storage: slot %0d got %h want %h", bad, slot_val(bad), exp_mem[bad]); end
      if (!TESTPAT) begin
         tests_run++;
         if (slot_val(79) !== 16'hA000 || slot_val(40) !== 16'hA027) begin
            tests_failed++;
            $display("FAIL upper ends: slot79=%h slot40=%h want a000/a027", slot_val(79), slot_val(40));
         end
      end
   endtask

   task automatic test_back_pressure();
      int st;
      int bad;
      fill_random(HALF);
      stream(HALF, HALF - 1, 75, 20, 0, 2'd2, -1, 2'd0, "backpressure", st);
      tests_run++;
      if (st != 2 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL backpressure ready: stalls=%0d in_ready_after=%b want 2/0", st, in_ready); end
      tests_run++;
      if (store_coun !== 11'd80) begin tests_failed++; $display("FAIL backpressure store_coun: got %0d want 80", store_coun); end
      bad = first_bad_slot();
      tests_run++;
      if (bad != -1) begin tests_failed++; $display("FAIL backpressure storage: slot %0d got %h want %h", bad, slot_val(bad), exp_mem[bad]); end
   endtask

   task automatic test_queued();
      int st;
      int bad;
      fill_random(SLOTS);
      // Upper then lower fill land in one contiguous descending run 79..0,
      // separated by the two latency cycles and one dead cycle.
      stream(SLOTS, SLOTS - 1, 100, -1, 0, 2'd1, 3, 2'd2, "queued", st);
      tests_run++;
      if (st != 3) begin tests_failed++; $display("FAIL queued dead cycles: got %0d idle cycles want 3", st); end
      tests_run++;
      if (underrun !== 1'b0) begin tests_failed++; $display("FAIL queued underrun: got %b want 0", underrun); end
      tests_run++;
      if (store_coun !== 11'd80) begin tests_failed++; $display("FAIL queued store_coun: got %0d want 80", store_coun); end
      bad = first_bad_slot();
      tests_run++;
      if (bad != -1) begin tests_failed++; $display("FAIL queued storage: slot %0d got %h want %h", bad, slot_val(bad), exp_mem[bad]); end
   endtask

   task automatic test_underrun();
      int st;
      int bad;
      need_pixel = 2'd1;
      @(negedge clk);
      tests_run++;
      if (underrun !== 1'b0 || store_coun !== 11'd40) begin
         tests_failed++;
         $display("FAIL underrun first: underrun=%b store_coun=%0d want 0/40", underrun, store_coun);
      end
      @(negedge clk);
      need_pixel = 2'd0;
      tests_run++;
      if (underrun !== 1'b1 || store_coun !== 11'd0) begin
         tests_failed++;
         $display("FAIL underrun second: underrun=%b store_coun=%0d want 1/0", underrun, store_coun);
      end
      fill_random(HALF);
      stream(HALF, SLOTS - 1, 60, -1, -1, 2'd0, -1, 2'd0, "underrun_fill", st);
      tests_run++;
      if (underrun !== 1'b1 || store_coun !== 11'd40) begin
         tests_failed++;
         $display("FAIL underrun sticky: underrun=%b store_coun=%0d want 1/40", underrun, store_coun);
      end
      bad = first_bad_slot();
      tests_run++;
      if (bad != -1) begin tests_failed++; $display("FAIL underrun storage: slot %0d got %h want %h", bad, slot_val(bad), exp_mem[bad]); end
   endtask

   task automatic test_zoom();
      int st;
      int bad;
      fill_random(24);
      // Upper refill runs through slots 79..56; the next write would hit 55.
      stream(24, SLOTS - 1, 100, -1, 0, 2'd1, -1, 2'd0, "zoom_pre", st);
      zoom     = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL zoom ready: in_ready=%b want 0 while zoom high", in_ready); end
      @(negedge clk);
      zoom     = 1'b0;
      in_valid = 1'b0;
      wr_x     = 0;
      #1;
      tests_run++;
      if (start !== 1'b0 || store_coun !== 11'd0) begin
         tests_failed++;
         $display("FAIL zoom flush: start=%b store_coun=%0d want 0/0", start, store_coun);
      end
      tests_run++;
      if (slot_val(55) !== exp_mem[55]) begin tests_failed++; $display("FAIL zoom no write: slot55 got %h want %h", slot_val(55), exp_mem[55]); end
      tests_run++;
      if (in_ready !== 1'b1 || underrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL zoom reprime: in_ready=%b underrun=%b want 1/1", in_ready, underrun);
      end
      fill_random(SLOTS);
      stream(SLOTS, SLOTS - 1, 80, -1, -1, 2'd0, -1, 2'd0, "zoom_prime", st);
      tests_run++;
      if (start !== 1'b1 || store_coun !== 11'd80) begin
         tests_failed++;
         $display("FAIL zoom primed: start=%b store_coun=%0d want 1/80", start, store_coun);
      end
      bad = first_bad_slot();
      tests_run++;
      if (bad != -1) begin tests_failed++; $display("FAIL zoom storage: slot %0d got %h want %h", bad, slot_val(bad), exp_mem[bad]); end
      if (TESTPAT) begin
         tests_run++;
         if (slot_val(79) !== 16'h0000 || slot_val(78) !== 16'h0821) begin
            tests_failed++;
            $display("FAIL zoom pattern: slot79=%h slot78=%h want 0000/0821", slot_val(79), slot_val(78));
         end
      end
   endtask

   task automatic test_reset_clears();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (underrun !== 1'b0 || start !== 1'b0 || store_coun !== 11'd0) begin
         tests_failed++;
         $display("FAIL reset clears: underrun=%b start=%b store_coun=%0d want 0/0/0", underrun, start, store_coun);
      end
   endtask

   initial begin
      rst        = 1'b1;
      zoom       = 1'b0;
      need_pixel = 2'd0;
      in_valid   = 1'b0;
      in_data    = '0;
      wr_x       = 0;
      @(negedge clk);
      test_reset();
      test_prime();
      test_upper_refill();
      test_back_pressure();
      test_queued();
      test_underrun();
      test_zoom();
      test_reset_clears();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vga_pixel_feeder.md
Name: vga_pixel_feeder

Overview:
- Upstream stage of the VGA scan-out block; owns and fills the 80-pixel, 1280-bit ping-pong `storage` register that the scan-out consumes.
- Accepts RGB565 pixels from the fractal engine over a valid/ready stream.
- Primes both halves, then raises `start`.
- Refills the upper half (pixel slots 79..40) or lower half (slots 39..0) on each `need_pixel` request from scan-out.

Parameters:
- SLOTS, 80, total pixel slots in storage (must be even).
- PIX_W, 16, pixel width (RGB565: r[15:11] g[10:5] b[4:0]).
- HALF, SLOTS/2, slots per half (derived, not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- zoom  in  1  view change; flushes buffer and re-primes.
- need_pixel  in  2  scan-out request, one-cycle pulse. 1 = refill upper half, 2 = refill lower half, 0/3 = none.
- in_valid  in  1  input pixel valid.
- in_data  in  16  input pixel, RGB565.
- in_ready  out  1  feeder accepts in_data this cycle.
- storage  out  1280  pixel slots; slot k at bits [k*16 +: 16].
- store_coun  out  11  pixels currently held and not yet consumed (0..80).
- start  out  1  buffer primed; scan-out may run.
- underrun  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0, including storage and store_coun. State = PRIME, write slot = 79, pending flags cleared.
- Write order: slots fill in descending order. Every write is a handshake (in_valid && in_ready) that stores in_data in the current slot in the same cycle, then decrements the slot. The value is visible on storage the next cycle.
- States:
  - PRIME: in_ready = 1; fills slots 79..0 (80 writes). After the write to slot 0: start <= 1, store_coun = 80, go to WAIT.
  - WAIT: in_ready = 0.
    - If pend_hi is set: go to FILL_HI, slot = 79.
    - Otherwise, if pend_lo is set: go to FILL_LO, slot = 39.
  - FILL_HI: in_ready = 1; writes slots 79..40. After the write to slot 40: clear pend_hi, store_coun += 40, go to WAIT.
  - FILL_LO: same as FILL_HI over slots 39..0; clears pend_lo.
- Request capture:
  - need_pixel == 1 sets pend_hi; need_pixel == 2 sets pend_lo; both apply store_coun -= 40, saturating at 0.
  - A request is captured in any state except PRIME, where it is ignored.
  - A request arriving in the same cycle as the final write of a fill is still captured.
  - A pend_lo raised during FILL_HI is served immediately after FILL_HI completes, via WAIT (one dead cycle).
  - need_pixel == 3 is ignored.
- Underrun: underrun <= 1 (sticky until rst) when a request arrives while that same half's pending flag is still set. Example: need_pixel == 1 while pend_hi is set. The condition means scan-out wrapped onto unfilled data. Feeder behaviour is otherwise unchanged.
- Zoom (highest priority, any state):
  - start <= 0, store_coun <= 0, pending flags cleared, state = PRIME, slot = 79, in_ready = 0 that cycle.
  - Storage contents are retained; no clearing is needed.
  - Priming resumes the cycle after zoom deasserts.
- store_coun arithmetic is 11-bit unsigned. Increments happen only at the completion of PRIME or a fill, never per pixel.
- in_ready is a registered-state decode only; it has no combinational path from in_valid.
- Throughput: 1 pixel/cycle while filling. Refill latency from request to first write is 2 cycles (capture, then WAIT->FILL).

Optional Feature:
- Macro: VGA_FEEDER_TESTPAT_EN.
- Defined:
  - in_valid and in_data are ignored; in_ready is still driven.
  - An internal 16-bit generator supplies the pixels, always valid.
  - Value = {x[4:0], x[5:0], x[4:0]}, where x is a 6-bit counter that increments per write and resets to 0 on rst and on zoom.
- Undefined: no generator logic is synthesised; pixels come from in_data.

Test Plan:
- Reset then prime: rst 1 cycle; stream 80 pixels with values 0x0000..0x004F, in_valid held high. Required: storage[1279:1264] = 0x0000, storage[15:0] = 0x004F, start = 1 the cycle after the 80th write, store_coun = 80.
- Upper refill: after priming, pulse need_pixel = 1; stream 0xA000..0xA027. Required: in_ready rises 2 cycles after the pulse and stays high for 40 accepted writes; slot 79 = 0xA000, slot 40 = 0xA027; lower half unchanged; store_coun goes 80 -> 40 -> 80.
- Back-pressure: during FILL_LO, drop in_valid for 5 cycles mid-fill. Required: the slot index holds; no slot is skipped; fill completes after exactly 40 accepted pixels.
- Queued requests: need_pixel = 1, then need_pixel = 2 three cycles later during FILL_HI. Required: FILL_LO starts one cycle after FILL_HI ends; underrun = 0.
- Underrun: need_pixel = 1 twice with no input data between. Required: underrun = 1 after the second pulse and stays 1 until rst.
- Zoom mid-fill: assert zoom at slot 55 of FILL_HI. Required: next cycle start = 0, store_coun = 0, state PRIME; after zoom drops, the next write lands in slot 79. With VGA_FEEDER_TESTPAT_EN defined, slot 79 = 0x0000 and slot 78 = 0x0821.
